// File: rtl/pair_match_pkg.sv
// Shared types and helpers for the memory-game turn/match controller.
package pair_match_pkg;

    localparam int MAX_CARDS   = 16;
    localparam int MAX_LABEL_W = 8;

    typedef enum logic [1:0] {
        HIDDEN   = 2'b00,
        UP       = 2'b01,
        MATCH_P1 = 2'b10,
        MATCH_P2 = 2'b11
    } card_state_e;

    typedef enum logic [2:0] {
        PICK1     = 3'd0,
        PICK2     = 3'd1,
        COMPARE   = 3'd2,
        SHOW_MISS = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    typedef logic [MAX_CARDS*MAX_LABEL_W-1:0] label_tbl_t;

    // Caller truncates the result to its own label width.
    function automatic logic [MAX_LABEL_W-1:0] label_at(input label_tbl_t tbl,
                                                        input int unsigned lw,
                                                        input int unsigned idx);
        return MAX_LABEL_W'(tbl >> (idx * lw));
    endfunction

    function automatic logic [1:0] winner_of(input logic [3:0] s1, input logic [3:0] s2);
        if (s1 > s2)      return WIN_P1;
        else if (s2 > s1) return WIN_P2;
        else              return WIN_TIE;
    endfunction

endpackage

// File: rtl/pair_match_ctrl_cycle_timer.sv
// Loadable down-counter; expired is high for the single enabled cycle that counts 1 -> 0.
module cycle_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] RELOAD = W'(CYCLES);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = RELOAD;
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= RELOAD;
        else      cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == W'(1));

endmodule

// File: rtl/pair_match_ctrl.sv
// Turn and match sequencer for the memory game.
// Optional turn timer is enabled with `define TURN_TIMEOUT_EN.
module pair_match_ctrl
    import pair_match_pkg::*;
#(
    parameter int N_CARDS       = 16,
    parameter int LABEL_W       = 4,
    parameter int REVEAL_CYCLES = 50_000_000,
    parameter int TURN_CYCLES   = 500_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       select,
    input  logic [3:0]                 cursor,
    input  logic [N_CARDS*LABEL_W-1:0] labels,
    output logic [N_CARDS*2-1:0]       card_st,
    output logic                       player,
    output logic [3:0]                 score1,
    output logic [3:0]                 score2,
    output logic                       busy,
    output logic                       sel_err,
    output logic                       turn_to,
    output logic                       game_over,
    output logic [1:0]                 winner
);

    localparam int IDX_W = (N_CARDS > 2) ? $clog2(N_CARDS) : 1;
    localparam logic [3:0] PAIRS_INIT = 4'(N_CARDS / 2);
    localparam logic [4:0] N_CARDS_5  = 5'(N_CARDS);

    state_e            state_q, state_d;
    card_state_e       card_q [N_CARDS];
    card_state_e       card_d [N_CARDS];
    logic [IDX_W-1:0]  idx1_q, idx1_d, idx2_q, idx2_d;
    logic              player_q, player_d;
    logic [3:0]        score1_q, score1_d, score2_q, score2_d;
    logic [3:0]        pairs_left_q, pairs_left_d;
    logic              busy_q, busy_d, sel_err_q, sel_err_d, turn_to_q, turn_to_d;
    logic              game_over_q, game_over_d;
    logic [1:0]        winner_q, winner_d;

    label_tbl_t        tbl;
    logic [LABEL_W-1:0] lbl1, lbl2;
    logic              cursor_ok, cur_hidden, accept_sel, labels_eq;
    logic [IDX_W-1:0]  cur_idx;
    logic              reveal_load, reveal_en, reveal_exp, turn_exp;

    assign tbl       = label_tbl_t'(labels);
    assign lbl1      = LABEL_W'(label_at(tbl, LABEL_W, 32'(idx1_q)));
    assign lbl2      = LABEL_W'(label_at(tbl, LABEL_W, 32'(idx2_q)));
    assign labels_eq = (lbl1 == lbl2);

    assign cursor_ok  = ({1'b0, cursor} < N_CARDS_5);
    assign cur_idx    = cursor[IDX_W-1:0];
    assign cur_hidden = cursor_ok && (card_q[cur_idx] == HIDDEN);
    assign accept_sel = select && cur_hidden &&
                        ((state_q == PICK1) || ((state_q == PICK2) && (cur_idx != idx1_q)));

    assign reveal_load = (state_q == COMPARE) && !labels_eq;
    assign reveal_en   = (state_q == SHOW_MISS);

    cycle_timer #(.CYCLES(REVEAL_CYCLES)) u_reveal_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (reveal_load),
        .en      (reveal_en),
        .expired (reveal_exp)
    );

`ifdef TURN_TIMEOUT_EN
    logic turn_load, turn_en;
    assign turn_en   = (state_q == PICK1) || (state_q == PICK2);
    // Reload on every accepted select, after a timeout, and whenever PICK1 is re-entered.
    assign turn_load = accept_sel || turn_exp || ((state_d == PICK1) && (state_q != PICK1));

    cycle_timer #(.CYCLES(TURN_CYCLES)) u_turn_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (turn_load),
        .en      (turn_en),
        .expired (turn_exp)
    );
`else
    assign turn_exp = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        card_d       = card_q;
        idx1_d       = idx1_q;
        idx2_d       = idx2_q;
        player_d     = player_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        pairs_left_d = pairs_left_q;
        sel_err_d    = 1'b0;
        turn_to_d    = 1'b0;

        case (state_q)
            PICK1: begin
                if (accept_sel) begin
                    card_d[cur_idx] = UP;
                    idx1_d          = cur_idx;
                    state_d         = PICK2;
                end else begin
                    sel_err_d = select;
                    if (turn_exp) begin
                        turn_to_d = 1'b1;
                        player_d  = ~player_q;
                    end
                end
            end
            PICK2: begin
                if (accept_sel) begin
                    card_d[cur_idx] = UP;
                    idx2_d          = cur_idx;
                    state_d         = COMPARE;
                end else begin
                    sel_err_d = select;
                    if (turn_exp) begin
                        card_d[idx1_q] = HIDDEN;
                        turn_to_d      = 1'b1;
                        player_d       = ~player_q;
                        state_d        = PICK1;
                    end
                end
            end
            COMPARE: begin
                if (labels_eq) begin
                    card_d[idx1_q] = player_q ? MATCH_P2 : MATCH_P1;
                    card_d[idx2_q] = player_q ? MATCH_P2 : MATCH_P1;
                    if (player_q) score2_d = score2_q + 4'd1;
                    else          score1_d = score1_q + 4'd1;
                    pairs_left_d = pairs_left_q - 4'd1;
                    state_d      = (pairs_left_q == 4'd1) ? DONE : PICK1;
                end else begin
                    state_d = SHOW_MISS;
                end
            end
            SHOW_MISS: begin
                if (reveal_exp) begin
                    card_d[idx1_q] = HIDDEN;
                    card_d[idx2_q] = HIDDEN;
                    player_d       = ~player_q;
                    state_d        = PICK1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = PICK1;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it.
        busy_d      = (state_d == COMPARE) || (state_d == SHOW_MISS);
        game_over_d = (state_d == DONE);
        winner_d    = (state_d == DONE) ? winner_of(score1_d, score2_d) : WIN_NONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PICK1;
            for (int i = 0; i < N_CARDS; i++) card_q[i] <= HIDDEN;
            idx1_q       <= '0;
            idx2_q       <= '0;
            player_q     <= 1'b0;
            score1_q     <= '0;
            score2_q     <= '0;
            pairs_left_q <= PAIRS_INIT;
            busy_q       <= 1'b0;
            sel_err_q    <= 1'b0;
            turn_to_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= WIN_NONE;
        end else begin
            state_q      <= state_d;
            card_q       <= card_d;
            idx1_q       <= idx1_d;
            idx2_q       <= idx2_d;
            player_q     <= player_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            pairs_left_q <= pairs_left_d;
            busy_q       <= busy_d;
            sel_err_q    <= sel_err_d;
            turn_to_q    <= turn_to_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    for (genvar g = 0; g < N_CARDS; g++) begin : g_card_out
        assign card_st[2*g +: 2] = card_q[g];
    end

    assign player    = player_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign busy      = busy_q;
    assign sel_err   = sel_err_q;
    assign turn_to   = turn_to_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pair_match_ctrl.sv
// Directed bench for pair_match_ctrl: 16-card instance plus an 8-card instance for range rejects.
module tb_pair_match_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        select = 1'b0;
    logic [3:0]  cursor = 4'd0;
    logic [63:0] labels;
    logic [31:0] card_st;
    logic        player, busy, sel_err, turn_to, game_over;
    logic [3:0]  score1, score2;
    logic [1:0]  winner;

    logic        select8 = 1'b0;
    logic [3:0]  cursor8 = 4'd0;
    logic [31:0] labels8;
    logic [15:0] card_st8;
    logic        player8, busy8, sel_err8, turn_to8, game_over8;
    logic [3:0]  score1_8, score2_8;
    logic [1:0]  winner8;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] lab  [16] = '{4'd1, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6,
                              4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd1, 4'd9, 4'd9};
    logic [3:0] lab8 [8]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3, 4'd4};
    int pa [8] = '{0, 1, 3, 5, 7,  9, 11, 14};
    int pb [8] = '{13, 2, 4, 6, 8, 10, 12, 15};

    pair_match_ctrl #(.N_CARDS(16), .LABEL_W(4), .REVEAL_CYCLES(4), .TURN_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .select(select), .cursor(cursor), .labels(labels),
        .card_st(card_st), .player(player), .score1(score1), .score2(score2),
        .busy(busy), .sel_err(sel_err), .turn_to(turn_to), .game_over(game_over),
        .winner(winner)
    );

    pair_match_ctrl #(.N_CARDS(8), .LABEL_W(4), .REVEAL_CYCLES(4), .TURN_CYCLES(10)) dut8 (
        .clk(clk), .rst(rst), .select(select8), .cursor(cursor8), .labels(labels8),
        .card_st(card_st8), .player(player8), .score1(score1_8), .score2(score2_8),
        .busy(busy8), .sel_err(sel_err8), .turn_to(turn_to8), .game_over(game_over8),
        .winner(winner8)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [1:0] cs(input int i);
        return card_st[2*i +: 2];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int c);
        cursor = 4'(c);
        select = 1'b1;
        tick();
        select = 1'b0;
    endtask

    task automatic pulse8(input int c);
        cursor8 = 4'(c);
        select8 = 1'b1;
        tick();
        select8 = 1'b0;
    endtask

    task automatic do_reset;
        select  = 1'b0;
        select8 = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic play_pair(input int p);
        pulse(pa[p]);
        pulse(pb[p]);
        tick();
    endtask

    task automatic play_miss;
        int n;
        pulse(9);
        pulse(11);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL miss_wait: busy still high after %0d cycles, required low", n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        vectors++;
        if (card_st !== 32'h0 || player !== 1'b0 || score1 !== 4'd0 || score2 !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: card_st=%h player=%b s1=%0d s2=%0d, required 0", card_st, player, score1, score2);
        end
        vectors++;
        if ({busy, sel_err, turn_to, game_over, winner} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy/sel_err/turn_to/game_over/winner=%b, required 000000",
                     {busy, sel_err, turn_to, game_over, winner});
        end
        do_reset();
    endtask

    task automatic test_match;
        do_reset();
        pulse(0);
        vectors++;
        if (cs(0) !== 2'b01) begin
            miscompares++;
            $display("FAIL match_first_up: card0=%b, required 01", cs(0));
        end
        pulse(13);
        vectors++;
        if (cs(13) !== 2'b01 || busy !== 1'b1 || score1 !== 4'd0) begin
            miscompares++;
            $display("FAIL match_compare: card13=%b busy=%b s1=%0d, required 01 1 0", cs(13), busy, score1);
        end
        tick();
        vectors++;
        if (cs(0) !== 2'b10 || cs(13) !== 2'b10 || score1 !== 4'd1 || player !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL match_result: c0=%b c13=%b s1=%0d player=%b busy=%b, required 10 10 1 0 0",
                     cs(0), cs(13), score1, player, busy);
        end
    endtask

    task automatic test_rejects;
        pulse(13);
        vectors++;
        if (sel_err !== 1'b1 || cs(13) !== 2'b10) begin
            miscompares++;
            $display("FAIL rej_match_card: sel_err=%b c13=%b, required 1 10", sel_err, cs(13));
        end
        tick();
        vectors++;
        if (sel_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rej_pulse_width: sel_err=%b, required 0", sel_err);
        end
        pulse(5);
        vectors++;
        if (cs(5) !== 2'b01 || sel_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rej_flip5: c5=%b sel_err=%b, required 01 0", cs(5), sel_err);
        end
        pulse(5);
        vectors++;
        if (sel_err !== 1'b1) begin
            miscompares++;
            $display("FAIL rej_up_card: sel_err=%b, required 1", sel_err);
        end
        pulse(0);
        vectors++;
        if (sel_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rej_match_in_pick2: sel_err=%b busy=%b, required 1 0", sel_err, busy);
        end
        pulse(6);
        tick();
        vectors++;
        if (score1 !== 4'd2 || cs(5) !== 2'b10 || cs(6) !== 2'b10) begin
            miscompares++;
            $display("FAIL rej_then_match: s1=%0d c5=%b c6=%b, required 2 10 10", score1, cs(5), cs(6));
        end
    endtask

    task automatic test_mismatch;
        int n;
        logic saw_err;
        do_reset();
        pulse(0);
        pulse(1);
        vectors++;
        if (cs(0) !== 2'b01 || cs(1) !== 2'b01) begin
            miscompares++;
            $display("FAIL miss_both_up: c0=%b c1=%b, required 01 01", cs(0), cs(1));
        end
        n = 0;
        saw_err = 1'b0;
        while (busy === 1'b1 && n < 20) begin
            if (n == 1) begin
                cursor = 4'd2;
                select = 1'b1;
            end else begin
                select = 1'b0;
            end
            tick();
            n++;
            saw_err = saw_err | sel_err;
        end
        select = 1'b0;
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL miss_busy_len: busy cycles=%0d, required 5", n);
        end
        vectors++;
        if (saw_err !== 1'b0 || cs(2) !== 2'b00) begin
            miscompares++;
            $display("FAIL miss_drop_select: sel_err seen=%b c2=%b, required 0 00", saw_err, cs(2));
        end
        vectors++;
        if (cs(0) !== 2'b00 || cs(1) !== 2'b00 || player !== 1'b1 || score1 !== 4'd0) begin
            miscompares++;
            $display("FAIL miss_result: c0=%b c1=%b player=%b s1=%0d, required 00 00 1 0",
                     cs(0), cs(1), player, score1);
        end
    endtask

    task automatic test_reset_mid;
        pulse(3);
        pulse(5);
        tick();
        vectors++;
        if (busy !== 1'b1 || player !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_pre: busy=%b player=%b, required 1 1", busy, player);
        end
        rst = 1'b0;
        #2;
        vectors++;
        if (card_st !== 32'h0 || player !== 1'b0 || busy !== 1'b0 || score1 !== 4'd0 || score2 !== 4'd0) begin
            miscompares++;
            $display("FAIL rmid_async: card_st=%h player=%b busy=%b s1=%0d s2=%0d, required 0",
                     card_st, player, busy, score1, score2);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_full_game;
        logic [31:0] exp_st;
        do_reset();
        for (int p = 0; p < 5; p++) play_pair(p);
        play_miss();
        vectors++;
        if (player !== 1'b1 || score1 !== 4'd5) begin
            miscompares++;
            $display("FAIL game_handover: player=%b s1=%0d, required 1 5", player, score1);
        end
        play_pair(5);
        play_pair(6);
        pulse(pa[7]);
        pulse(pb[7]);
        vectors++;
        if (game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL game_early_over: game_over=%b, required 0", game_over);
        end
        tick();
        exp_st = '0;
        for (int p = 0; p < 8; p++) begin
            exp_st[2*pa[p] +: 2] = (p < 5) ? 2'b10 : 2'b11;
            exp_st[2*pb[p] +: 2] = (p < 5) ? 2'b10 : 2'b11;
        end
        vectors++;
        if (game_over !== 1'b1 || winner !== 2'b01 || score1 !== 4'd5 || score2 !== 4'd3) begin
            miscompares++;
            $display("FAIL game_5_3: over=%b winner=%b s1=%0d s2=%0d, required 1 01 5 3",
                     game_over, winner, score1, score2);
        end
        vectors++;
        if (card_st !== exp_st) begin
            miscompares++;
            $display("FAIL game_cards: card_st=%h, required %h", card_st, exp_st);
        end
        pulse(1);
        vectors++;
        if (sel_err !== 1'b0 || game_over !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_select: sel_err=%b over=%b busy=%b, required 0 1 0", sel_err, game_over, busy);
        end
    endtask

    task automatic test_tie_game;
        do_reset();
        for (int p = 0; p < 4; p++) play_pair(p);
        play_miss();
        for (int p = 4; p < 8; p++) play_pair(p);
        vectors++;
        if (game_over !== 1'b1 || winner !== 2'b11 || score1 !== 4'd4 || score2 !== 4'd4) begin
            miscompares++;
            $display("FAIL game_tie: over=%b winner=%b s1=%0d s2=%0d, required 1 11 4 4",
                     game_over, winner, score1, score2);
        end
    endtask

    task automatic test_range;
        do_reset();
        pulse8(15);
        vectors++;
        if (sel_err8 !== 1'b1 || card_st8 !== 16'h0) begin
            miscompares++;
            $display("FAIL range_15: sel_err=%b card_st=%h, required 1 0000", sel_err8, card_st8);
        end
        pulse8(7);
        vectors++;
        if (card_st8[15:14] !== 2'b01 || sel_err8 !== 1'b0) begin
            miscompares++;
            $display("FAIL range_flip7: c7=%b sel_err=%b, required 01 0", card_st8[15:14], sel_err8);
        end
        pulse8(8);
        vectors++;
        if (sel_err8 !== 1'b1 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL range_8: sel_err=%b busy=%b, required 1 0", sel_err8, busy8);
        end
        pulse8(3);
        tick();
        vectors++;
        if (score1_8 !== 4'd1 || card_st8[7:6] !== 2'b10 || card_st8[15:14] !== 2'b10) begin
            miscompares++;
            $display("FAIL range_match: s1=%0d c3=%b c7=%b, required 1 10 10",
                     score1_8, card_st8[7:6], card_st8[15:14]);
        end
    endtask

    task automatic test_turn_timeout;
        do_reset();
        pulse(0);
`ifdef TURN_TIMEOUT_EN
        repeat (9) tick();
        vectors++;
        if (turn_to !== 1'b0 || cs(0) !== 2'b01) begin
            miscompares++;
            $display("FAIL to_early: turn_to=%b c0=%b, required 0 01", turn_to, cs(0));
        end
        tick();
        vectors++;
        if (turn_to !== 1'b1 || cs(0) !== 2'b00 || player !== 1'b1) begin
            miscompares++;
            $display("FAIL to_expire: turn_to=%b c0=%b player=%b, required 1 00 1", turn_to, cs(0), player);
        end
        tick();
        vectors++;
        if (turn_to !== 1'b0) begin
            miscompares++;
            $display("FAIL to_pulse_width: turn_to=%b, required 0", turn_to);
        end
        repeat (8) tick();
        pulse(0);
        vectors++;
        if (turn_to !== 1'b0 || cs(0) !== 2'b01 || player !== 1'b1) begin
            miscompares++;
            $display("FAIL to_select_wins: turn_to=%b c0=%b player=%b, required 0 01 1", turn_to, cs(0), player);
        end
`else
        begin
            logic saw_to;
            saw_to = 1'b0;
            repeat (15) begin
                tick();
                saw_to = saw_to | turn_to;
            end
            vectors++;
            if (saw_to !== 1'b0 || cs(0) !== 2'b01 || player !== 1'b0) begin
                miscompares++;
                $display("FAIL no_timeout: turn_to seen=%b c0=%b player=%b, required 0 01 0", saw_to, cs(0), player);
            end
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) labels[i*4 +: 4] = lab[i];
        for (int i = 0; i < 8; i++)  labels8[i*4 +: 4] = lab8[i];
        #1;
        test_reset();
        test_match();
        test_rejects();
        test_mismatch();
        test_reset_mid();
        test_full_game();
        test_tie_game();
        test_range();
        test_turn_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
